byte_queue: RTL and testbench



---
 rtl/byte_queue_pkg.sv | 13 +
 rtl/rise_detect.sv | 21 ++
 rtl/byte_queue.sv | 115 +++++++++++
 tb/tb_byte_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_queue_pkg.sv
// Shared types and sizing for the deserializer output queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package byte_queue_pkg;

  localparam int QUEUE_DEPTH = 8;
  localparam int QUEUE_WIDTH = 8;

  typedef enum logic [1:0] {ENQ_IDLE, ENQ_ACK, ENQ_RELEASE} enq_state_t;

  typedef logic [QUEUE_WIDTH-1:0] byte_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: pulses while d is high and was low on the previous clock.
// Latency: combinational against one registered history bit.
// Backpressure: none; every edge is reported once.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember last cycle's level; reset forgets it so a level held through reset is seen as new.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/byte_queue.sv
// Eight-entry byte FIFO between the deserializer and the user; optional BYTE_QUEUE_FWFT_EN shows the head directly.
// Latency: byte stored on the accepting edge, ack_out one cycle later; dequeued byte on data_out after the edge.
// Backpressure: when full the deserializer's level request is left pending until a dequeue makes room.
module byte_queue
  import byte_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = QUEUE_WIDTH
) (
  input  logic                     clock_10KHz,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     enqueue_in,
  output logic                     ack_out,
  input  logic                     dequeue_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full_out,
  output logic                     empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [LW-1:0]    len;
  enq_state_t       state;
  enq_state_t       state_nxt;
  logic             deq_rise;
  logic             dq_fire;
  logic             wr_fire;
  logic             is_full;
  logic             is_empty;

  rise_detect u_deq_edge (
    .clk  (clock_10KHz),
    .rst  (rst),
    .d    (dequeue_in),
    .rise (deq_rise)
  );

  // Fullness/emptiness are judged on the registered count, i.e. at the start of the cycle.
  assign is_full  = (len == LW'(DEPTH));
  assign is_empty = (len == '0);
  assign dq_fire  = deq_rise & ~is_empty;

  // Enqueue handshake: accept once, pulse ack, then insist the request drops before re-arming.
  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    case (state)
      ENQ_IDLE: begin
        if (enqueue_in && (!is_full || dq_fire)) begin
          wr_fire   = 1'b1;
          state_nxt = ENQ_ACK;
        end
      end
      ENQ_ACK:     state_nxt = ENQ_RELEASE;
      ENQ_RELEASE: if (!enqueue_in) state_nxt = ENQ_IDLE;
      default:     state_nxt = ENQ_IDLE;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clock_10KHz) begin
    if (rst) state <= ENQ_IDLE;
    else     state <= state_nxt;
  end

  // Storage array is deliberately not reset; only the pointers and count define validity.
  always_ff @(posedge clock_10KHz) begin
    if (wr_fire && !rst) mem[wp] <= data_in;
  end

  // Pointers, occupancy and the registered ack pulse.
  always_ff @(posedge clock_10KHz) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      len     <= '0;
      ack_out <= 1'b0;
    end else begin
      if (wr_fire) wp <= wp + 1'b1;
      if (dq_fire) rp <= rp + 1'b1;
      case ({wr_fire, dq_fire})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: len <= len;
      endcase
      ack_out <= (state == ENQ_ACK);
    end
  end

  assign len_out   = len;
  assign full_out  = is_full;
  assign empty_out = is_empty;

`ifdef BYTE_QUEUE_FWFT_EN
  // Head of queue shown directly; zero while nothing is stored.
  assign data_out = is_empty ? '0 : mem[rp];
`else
  logic [WIDTH-1:0] data_q;

  // Hold the most recently dequeued byte.
  always_ff @(posedge clock_10KHz) begin
    if (rst)          data_q <= '0;
    else if (dq_fire) data_q <= mem[rp];
  end

  assign data_out = data_q;
`endif

endmodule

// File: tb/tb_byte_queue.sv
module tb_byte_queue;
  import byte_queue_pkg::*;

  logic        clock_10KHz = 1'b0;
  logic        rst         = 1'b1;
  logic [7:0]  data_in     = '0;
  logic        enqueue_in  = 1'b0;
  logic        dequeue_in  = 1'b0;
  logic        ack_out;
  logic [7:0]  data_out;
  logic [3:0]  len_out;
  logic        full_out;
  logic        empty_out;

  always #5 clock_10KHz = ~clock_10KHz;

  byte_queue dut (
    .clock_10KHz (clock_10KHz),
    .rst         (rst),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .ack_out     (ack_out),
    .dequeue_in  (dequeue_in),
    .data_out    (data_out),
    .len_out     (len_out),
    .full_out    (full_out),
    .empty_out   (empty_out)
  );

  typedef struct {
    logic [3:0] len;
    logic       full;
    logic       empty;
    logic       ack;
    logic [7:0] data;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mon_cyc = 0;

  // Reference model: a plain byte list plus handshake bookkeeping.
  logic [7:0] mq[$];
  logic [7:0] m_data = '0;
  bit         m_prev_deq = 0;
  bit         m_wait_rel = 0;
  int         m_last_acc = -10;
  int         cyc = 0;
  bit         m_wr = 0;
  bit         m_ack = 0;

  task automatic model_edge(input bit r, input bit enq, input logic [7:0] din, input bit deq);
    exp_t e;
    bit   dq;
    m_wr = 0;
    if (r) begin
      mq.delete();
      m_data = '0;
      m_prev_deq = 0;
      m_wait_rel = 0;
      m_last_acc = -10;
      m_ack = 0;
    end else begin
      dq    = deq && !m_prev_deq && (mq.size() > 0);
      m_wr  = enq && !m_wait_rel && ((mq.size() < QUEUE_DEPTH) || dq);
      m_ack = (cyc == m_last_acc + 1);
      if (dq) m_data = mq.pop_front();
      if (m_wr) begin
        mq.push_back(din);
        m_wait_rel = 1;
        m_last_acc = cyc;
      end else if (m_wait_rel && !enq && (cyc >= m_last_acc + 2)) begin
        m_wait_rel = 0;
      end
      m_prev_deq = deq;
    end
    e.len   = 4'(mq.size());
    e.full  = (mq.size() == QUEUE_DEPTH);
    e.empty = (mq.size() == 0);
    e.ack   = m_ack;
`ifdef BYTE_QUEUE_FWFT_EN
    e.data  = (mq.size() > 0) ? mq[0] : 8'h00;
`else
    e.data  = m_data;
`endif
    expq.push_back(e);
    cyc++;
  endtask

  // Deserializer-side requester: holds a byte until acked, optionally lingers, then drops.
  logic [7:0] send_q[$];
  bit         req_on = 0;
  bit         acked = 0;
  logic [7:0] req_byte = '0;
  int         drop_cnt = 0;
  int         gap = 0;
  int         gap_max = 0;
  int         hold_extra = 0;

  task automatic tick(input bit r, input bit deq);
    if (req_on && acked) begin
      if (drop_cnt == 0) begin
        req_on = 0;
        acked  = 0;
        gap    = $urandom_range(0, gap_max);
      end else begin
        drop_cnt--;
      end
    end else if (!req_on) begin
      if (gap > 0) gap--;
      else if (send_q.size() > 0) begin
        req_on   = 1;
        req_byte = send_q.pop_front();
      end
    end
    @(negedge clock_10KHz);
    rst        = r;
    enqueue_in = req_on;
    data_in    = req_on ? req_byte : 8'($urandom);
    dequeue_in = deq;
    model_edge(r, req_on, data_in, deq);
    if (req_on && !acked && m_ack) begin
      acked    = 1;
      drop_cnt = hold_extra;
    end
  endtask

  task automatic idle(input int n, input bit deq);
    for (int i = 0; i < n; i++) tick(0, deq);
  endtask

  task automatic pulse_deq(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 1);
      tick(0, 0);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%02h, need 0x%02h", name, mon_cyc, act, exp);
    end
  endtask

  // Monitor: every edge driven by the stimulus has one expected snapshot queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_10KHz);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("len_out",   8'(len_out),   8'(e.len));
        chk("full_out",  8'(full_out),  8'(e.full));
        chk("empty_out", 8'(empty_out), 8'(e.empty));
        chk("ack_out",   8'(ack_out),   8'(e.ack));
        chk("data_out",  data_out,      e.data);
        mon_cyc++;
      end
    end
  end

  initial begin
    int pct;
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) tick(1, 0);

    // Handshake: request lingers after ack, must not double-enqueue.
    hold_extra = 3;
    send_q.push_back(8'hAA);
    idle(8, 0);
    send_q.push_back(8'h55);
    idle(8, 0);
    hold_extra = 0;

    // Drain, plus one extra edge on an empty queue.
    pulse_deq(3);

    // Fill to full, then a ninth request waits for room.
    for (int i = 1; i <= 9; i++) send_q.push_back(8'(i));
    idle(45, 0);
    pulse_deq(10);

    // Dequeue held high across an enqueue: no new edge, no dequeue.
    send_q.push_back(8'h33);
    idle(6, 1);
    tick(0, 0);
    pulse_deq(2);

    // Reset right after the fifth accept, while ack is still pending.
    for (int i = 0; i < 4; i++) send_q.push_back(8'($urandom));
    idle(16, 0);
    send_q.push_back(8'hC5);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      if (m_wr) break;
    end
    tick(1, 0);
    idle(6, 0);
    pulse_deq(3);

    // Randomized traffic with varying drain rates and occasional resets.
    gap_max = 2;
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0:       pct = 10;
        1:       pct = 50;
        default: pct = 90;
      endcase
      hold_extra = $urandom_range(0, 2);
      for (int i = 0; i < 200; i++) begin
        if (send_q.size() < 2) send_q.push_back(8'($urandom));
        tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < pct));
      end
    end
    idle(3, 0);

    repeat (4) @(posedge clock_10KHz);
    #2;
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending snapshots, need 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
